// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared hazard-controller state type and parameter defaults
package pipeline_pkg;
  localparam int REG_AW_DEF     = 3;
  localparam int WAIT_LIMIT_DEF = 255;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hazState_t;
endpackage

// File: rtl/sat_counter16.sv
// rtl/sat_counter16.sv - 16-bit enabled counter that holds at all-ones
module sat_counter16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] count
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (en && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush control for load-use, taken branch and slow data memory
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEF,
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemToRegE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic              BranchTakenE,
  input  logic              MemAccessM,
  input  logic              MemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              mem_timeout,
  output logic [15:0]       stall_count
);
  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  hazState_t  state;
  logic [7:0] waitCnt;
  logic       loadUse;
  logic       memStall;
  logic       branchFlush;
  logic       luStall;

  assign loadUse = MemToRegE && (WriteRegE != '0) &&
                   ((WriteRegE == RsD) || (WriteRegE == RtD));

  // Gating by reset keeps every control output quiet while reset is held.
  always_comb begin
    memStall    = 1'b0;
    branchFlush = 1'b0;
    luStall     = 1'b0;
    if (reset) begin
      if (state == MEM_WAIT) begin
        memStall = !MemReadyM;
      end else begin
        memStall    = MemAccessM && !MemReadyM;
        branchFlush = !memStall && BranchTakenE;
        luStall     = !memStall && !BranchTakenE && loadUse;
      end
    end
  end

  always_comb begin
    StallF = memStall || luStall;
    StallD = memStall || luStall;
    StallE = memStall;
    StallM = memStall;
    FlushD = branchFlush;
    FlushE = branchFlush || luStall;
    FlushW = memStall;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      waitCnt     <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (MemAccessM && !MemReadyM) begin
            state   <= MEM_WAIT;
            waitCnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (waitCnt == LIMIT) begin
            mem_timeout <= 1'b1;
          end
          // The counter holds at all-ones so it can never wrap back under the limit.
          if (MemReadyM) begin
            state <= RUN;
          end else if (waitCnt != 8'hFF) begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  sat_counter16 u_stallCount (
    .clk   (clk),
    .reset (reset),
    .en    (StallF),
    .count (stall_count)
  );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed vectors checked against a cycle model of the hazard rules
module tb_pipeline_hazard_ctrl;
  localparam int AW = 3;
  localparam int WL = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          MemToRegE = 1'b0;
  logic [AW-1:0] WriteRegE = '0;
  logic [AW-1:0] RsD = '0;
  logic [AW-1:0] RtD = '0;
  logic          BranchTakenE = 1'b0;
  logic          MemAccessM = 1'b0;
  logic          MemReadyM = 1'b0;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic          mem_timeout;
  logic [15:0]   stall_count;
  logic [6:0]    outs;

  int errors = 0;
  int checks = 0;

  bit mInWait = 1'b0;
  int mWaitCycles = 0;
  bit mTimeout = 1'b0;
  int mStallCnt = 0;

  pipeline_hazard_ctrl #(.REG_AW(AW), .WAIT_LIMIT(WL)) dut (
    .clk          (clk),
    .reset        (reset),
    .MemToRegE    (MemToRegE),
    .WriteRegE    (WriteRegE),
    .RsD          (RsD),
    .RtD          (RtD),
    .BranchTakenE (BranchTakenE),
    .MemAccessM   (MemAccessM),
    .MemReadyM    (MemReadyM),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .StallM       (StallM),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushW       (FlushW),
    .mem_timeout  (mem_timeout),
    .stall_count  (stall_count)
  );

  assign outs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(input bit m2r, input int wr, input int rs, input int rt,
                       input bit br, input bit acc, input bit rdy);
    MemToRegE    = m2r;
    WriteRegE    = AW'(wr);
    RsD          = AW'(rs);
    RtD          = AW'(rt);
    BranchTakenE = br;
    MemAccessM   = acc;
    MemReadyM    = rdy;
  endtask

  task automatic doReset();
    setIn(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  // Reference: inputs are stable from just after one rising edge to the next,
  // so the falling edge both checks this cycle and advances the model.
  always @(negedge clk) begin
    logic [6:0] exp;
    bit hazard;
    exp = '0;
    if (!reset) begin
      mInWait = 1'b0;
      mWaitCycles = 0;
      mTimeout = 1'b0;
      mStallCnt = 0;
    end else begin
      hazard = MemToRegE && (WriteRegE != 0) && (WriteRegE == RsD || WriteRegE == RtD);
      if (mInWait) begin
        if (!MemReadyM) exp = 7'b1111001;
      end else if (MemAccessM && !MemReadyM) begin
        exp = 7'b1111001;
      end else if (BranchTakenE) begin
        exp = 7'b0000110;
      end else if (hazard) begin
        exp = 7'b1100010;
      end
    end
    chk("model_outs", 32'(outs), 32'(exp));
    chk("model_timeout", 32'(mem_timeout), 32'(mTimeout));
    chk("model_stall_count", 32'(stall_count), 32'(mStallCnt));
    if (reset) begin
      if (exp[6] && mStallCnt < 65535) mStallCnt++;
      if (mInWait) begin
        if (mWaitCycles >= WL) mTimeout = 1'b1;
        if (MemReadyM) mInWait = 1'b0;
        else mWaitCycles++;
      end else if (MemAccessM && !MemReadyM) begin
        mInWait = 1'b1;
        mWaitCycles = 0;
      end
    end
  end

  initial begin
    #1 reset = 1'b0;
    setIn(1, 3, 3, 0, 1, 1, 0);
    #1;
    chk("reset_outs", 32'(outs), 32'h0);
    chk("reset_count", 32'(stall_count), 32'h0);
    chk("reset_timeout", 32'(mem_timeout), 32'h0);
    step();
    step();
    setIn(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step();

    setIn(1, 3, 3, 5, 0, 0, 0);
    #1 chk("loaduse_rs", 32'(outs), 32'b1100010);
    step();
    setIn(0, 0, 0, 0, 0, 0, 0);
    #1 chk("loaduse_release", 32'(outs), 32'h0);
    chk("loaduse_count", 32'(stall_count), 32'd1);
    step();
    setIn(1, 5, 1, 5, 0, 0, 0);
    #1 chk("loaduse_rt", 32'(outs), 32'b1100010);
    step();
    setIn(1, 0, 1, 0, 0, 0, 0);
    #1 chk("reg0_nohazard", 32'(outs), 32'h0);
    step();
    setIn(1, 3, 3, 0, 1, 0, 0);
    #1 chk("branch_over_loaduse", 32'(outs), 32'b0000110);
    step();

    doReset();
    for (int i = 0; i < 4; i++) begin
      setIn(1, 3, 3, 0, 1, 1, 0);
      #1 chk("memwait_stall", 32'(outs), 32'b1111001);
      step();
    end
    setIn(1, 3, 3, 0, 1, 1, 1);
    #1 chk("memwait_ready", 32'(outs), 32'h0);
    step();
    setIn(0, 0, 0, 0, 1, 0, 0);
    #1 chk("memwait_back_in_run", 32'(outs), 32'b0000110);
    chk("memwait_count", 32'(stall_count), 32'd4);
    step();

    doReset();
    setIn(0, 0, 0, 0, 0, 1, 0);
    step();
    for (int i = 0; i < 255; i++) step();
    chk("timeout_not_yet", 32'(mem_timeout), 32'h0);
    step();
    chk("timeout_set", 32'(mem_timeout), 32'h1);
    for (int i = 0; i < 44; i++) step();
    chk("timeout_still_waiting", 32'(outs), 32'b1111001);
    setIn(0, 0, 0, 0, 0, 1, 1);
    #1 chk("timeout_ready", 32'(outs), 32'h0);
    step();
    setIn(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("timeout_sticky", 32'(mem_timeout), 32'h1);

    doReset();
    setIn(0, 0, 0, 0, 0, 1, 0);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("midwait_reset_outs", 32'(outs), 32'h0);
    chk("midwait_reset_count", 32'(stall_count), 32'h0);
    chk("midwait_reset_timeout", 32'(mem_timeout), 32'h0);
    step();
    setIn(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    setIn(0, 0, 0, 0, 1, 0, 0);
    #1 chk("midwait_restart_run", 32'(outs), 32'b0000110);
    chk("midwait_restart_count", 32'(stall_count), 32'h0);
    step();
    setIn(0, 0, 0, 0, 0, 0, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
